// File: rtl/spi_pkg.sv
// Shared constants for the SPI initiator: FSM encoding, bus mode and default sizing.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Mode 0: sclk idles low, data captured on the leading (rising) edge.
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_master_if.sv
// Parallel request/response plus serial pins of the SPI initiator, bundled as one port.
interface spi_master_if #(
  parameter int DATA_W = spi_pkg::DEF_DATA_W
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, cs_n, sclk, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, cs_n, sclk, mosi
  );
endinterface

// File: rtl/spi_clk_gen.sv
// sclk divider: div_cnt wraps every CLK_DIV cycles (tick); sclk toggles on tick while sclk_en.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclk_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt;

  assign tick = en && (div_cnt == CW'(CLK_DIV - 1));
  assign rise = tick && sclk_en && !sclk;
  assign fall = tick && sclk_en &&  sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Forced back to idle level whenever not shifting, so SETUP/HOLD see a quiet clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk <= CPOL;
    end else if (!sclk_en) begin
      sclk <= CPOL;
    end else if (tick) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, one chip select.
// SPI_LOOPBACK_EN: capture the internal mosi instead of miso (rx_data == tx_data self-test).
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);
  localparam int BW = $clog2(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rx_data;
  logic [BW-1:0]     bit_cnt;
  logic              cs_n;
  logic              mosi;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              sample_bit;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state != IDLE),
    .sclk_en (state == SHIFT),
    .tick    (tick),
    .rise    (rise),
    .fall    (fall),
    .sclk    (sclk)
  );

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = bus.miso;
  assign sample_bit  = mosi;
`else
  assign sample_bit  = bus.miso;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg <= bus.tx_data;
            mosi  <= bus.tx_data[DATA_W-1];
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise) shreg <= {shreg[DATA_W-2:0], sample_bit};
          // After the rise shift, shreg MSB already holds the next bit to present.
          if (fall) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt < BW'(DATA_W - 1)) mosi  <= shreg[DATA_W-1];
            else                           state <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= shreg;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data = rx_data;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.cs_n    = cs_n;
  assign bus.sclk    = sclk;
  assign bus.mosi    = mosi;

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench: 8-bit/div-4 instance with a mode-0 slave model, 16-bit/div-2 with miso tied high.
module tb_spi_master;
  localparam int D8 = 8,  C8 = 4;
  localparam int D16 = 16, C16 = 2;
  localparam int LAT8  = (2*D8  + 2)*C8  + 1;
  localparam int LAT16 = (2*D16 + 2)*C16 + 1;
`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst16 = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(D8))  b8 ();
  spi_master_if #(.DATA_W(D16)) b16 ();

  spi_master #(.DATA_W(D8),  .CLK_DIV(C8))  u8  (.clk(clk), .rst(rst8),  .bus(b8));
  spi_master #(.DATA_W(D16), .CLK_DIV(C16)) u16 (.clk(clk), .rst(rst16), .bus(b16));

  typedef struct {
    logic [15:0] rx;
    logic [15:0] tx;
    int          due;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int checks = 0, errors = 0, cyc = 0, free8 = 0, free16 = 0;
  int fall8 = 0, nrise8 = 0, nrise16 = 0;
  logic [7:0]  sw8 = '0, slw = '0, mb8 = '0, last8 = '0;
  logic [15:0] mb16 = '0, last16 = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] model_rx(logic [15:0] tx, logic [15:0] slave);
    return LOOPBACK ? tx : slave;
  endfunction

  // Mode-0 slave: MSB out when selected, next bit after each sclk fall.
  always @(negedge b8.cs_n) begin slw = sw8; fall8 = 0; nrise8 = 0; mb8 = '0; end
  always @(negedge b8.sclk) if (!b8.cs_n) fall8++;
  always @(posedge b8.sclk) if (!b8.cs_n) begin mb8 = {mb8[6:0], b8.mosi}; nrise8++; end
  assign b8.miso = (fall8 < D8) ? slw[D8-1-fall8] : 1'b0;

  always @(negedge b16.cs_n) begin nrise16 = 0; mb16 = '0; end
  always @(posedge b16.sclk) if (!b16.cs_n) begin mb16 = {mb16[14:0], b16.mosi}; nrise16++; end
  assign b16.miso = 1'b1;

  // Reference model: an idle initiator accepts start and finishes LAT edges later.
  always @(posedge clk) begin
    cyc++;
    if (rst8) begin q8.delete(); free8 = 0; end
    else if (b8.start && cyc >= free8) begin
      q8.push_back('{rx: model_rx(16'(b8.tx_data), 16'(sw8)), tx: 16'(b8.tx_data), due: cyc + LAT8});
      free8 = cyc + LAT8;
    end
    if (rst16) begin q16.delete(); free16 = 0; end
    else if (b16.start && cyc >= free16) begin
      q16.push_back('{rx: model_rx(b16.tx_data, 16'hFFFF), tx: b16.tx_data, due: cyc + LAT16});
      free16 = cyc + LAT16;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    bit   eb, ed;
    if (rst8) begin last8 = '0; q8.delete(); end
    ed = (q8.size() > 0) && (q8[0].due == cyc + 1);
    eb = (q8.size() > 0) && !ed;
    chk("busy8", b8.busy, eb);
    chk("csn8", b8.cs_n, !eb);
    chk("done8", b8.done, ed);
    if (!eb) begin chk("sclk8_idle", b8.sclk, 0); chk("mosi8_idle", b8.mosi, 0); end
    if (b8.done && q8.size() > 0) begin
      e = q8.pop_front();
      chk("rx8", b8.rx_data, e.rx[7:0]);
      chk("mosi_bits8", mb8, e.tx[7:0]);
      chk("rises8", nrise8, D8);
      last8 = e.rx[7:0];
    end else chk("rxhold8", b8.rx_data, last8);

    if (rst16) begin last16 = '0; q16.delete(); end
    ed = (q16.size() > 0) && (q16[0].due == cyc + 1);
    eb = (q16.size() > 0) && !ed;
    chk("busy16", b16.busy, eb);
    chk("csn16", b16.cs_n, !eb);
    chk("done16", b16.done, ed);
    if (b16.done && q16.size() > 0) begin
      e = q16.pop_front();
      chk("rx16", b16.rx_data, e.rx);
      chk("mosi_bits16", mb16, e.tx);
      chk("rises16", nrise16, D16);
      last16 = e.rx;
    end else chk("rxhold16", b16.rx_data, last16);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send8(input logic [7:0] tx, input logic [7:0] sw);
    for (int i = 0; i < 500 && b8.busy; i++) step();
    chk("send8_wait", b8.busy, 0);
    b8.tx_data = tx; sw8 = sw; b8.start = 1'b1;
    step();
    b8.start = 1'b0;
  endtask

  task automatic wait8();
    for (int i = 0; i < 500; i++) begin
      if (q8.size() == 0 && !b8.busy) break;
      step();
    end
    chk("wait8_timeout", q8.size(), 0);
  endtask

  task automatic send16(input logic [15:0] tx);
    for (int i = 0; i < 500 && b16.busy; i++) step();
    chk("send16_wait", b16.busy, 0);
    b16.tx_data = tx; b16.start = 1'b1;
    step();
    b16.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (q16.size() == 0 && !b16.busy) break;
      step();
    end
    chk("wait16_timeout", q16.size(), 0);
  endtask

  initial begin
    b8.start = 1'b0;  b8.tx_data = '0;
    b16.start = 1'b0; b16.tx_data = '0;
    repeat (3) step();
    chk("rst_csn", b8.cs_n, 1);
    chk("rst_sclk", b8.sclk, 0);
    chk("rst_mosi", b8.mosi, 0);
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_rx", b8.rx_data, 0);
    chk("rst_csn16", b16.cs_n, 1);
    rst8 = 1'b0; rst16 = 1'b0;
    step();

    send8(8'hA5, 8'h3C); wait8();
    chk("dir_rx_a5", b8.rx_data, LOOPBACK ? 8'hA5 : 8'h3C);
    send8(8'h5A, 8'h00); wait8();
    chk("dir_rx_5a", b8.rx_data, LOOPBACK ? 8'h5A : 8'h00);

    // start held high through two transfers: 00 then FF, one-cycle cs_n gap
    b8.tx_data = 8'h00; sw8 = 8'hC3; b8.start = 1'b1;
    for (int i = 0; i < 300; i++) begin step(); if (b8.done) break; end
    chk("b2b_done_seen", b8.done, 1);
    chk("b2b_gap_hi", b8.cs_n, 1);
    b8.tx_data = 8'hFF; sw8 = 8'h81;
    step();
    chk("b2b_gap_lo", b8.cs_n, 0);
    b8.start = 1'b0;
    wait8();

    // reset while shifting bit 3, then a clean transfer
    send8(8'h96, 8'h69);
    for (int i = 0; i < 200 && nrise8 < 3; i++) step();
    rst8 = 1'b1;
    #1;
    chk("midrst_csn", b8.cs_n, 1);
    chk("midrst_sclk", b8.sclk, 0);
    chk("midrst_busy", b8.busy, 0);
    step(); step();
    rst8 = 1'b0;
    send8(8'h3E, 8'hD2); wait8();

    for (int n = 0; n < 30; n++) begin
      send8(8'($urandom), 8'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        repeat ($urandom_range(1, 20)) step();
        b8.tx_data = 8'($urandom); sw8 = 8'($urandom); b8.start = 1'b1;
        step();
        b8.start = 1'b0;
      end
    end
    wait8();

    send16(16'h8001);
    chk("dir_rx_8001", b16.rx_data, LOOPBACK ? 16'h8001 : 16'hFFFF);
    for (int n = 0; n < 6; n++) send16(16'($urandom));

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
